// File: rtl/uart_tx_rx_pkg.sv
// Shared definitions for the uart_tx_rx block: TX/RX state encodings and
// 8N1 frame constants used by both the transmitter and the receiver.
package uart_tx_rx_pkg;

   localparam int unsigned DATA_BITS = 8;
   localparam logic        LINE_IDLE = 1'b1;

   typedef enum logic [2:0] {
      TxIdle,
      TxStart,
      TxData,
      TxStop,
      TxDone
   } tx_state_e;

   typedef enum logic [2:0] {
      RxIdle,
      RxStart,
      RxData,
      RxStop,
      RxCleanup
   } rx_state_e;

endpackage

// File: rtl/uart_rx.sv
// 8N1 UART receiver.
// Ports:
//   clk        - rising-edge clock
//   rst_n      - asynchronous active-low reset
//   serial     - asynchronous RX line, idle high
//   data       - last correctly framed byte, held until the next good frame
//   data_valid - one-cycle pulse when data is updated
module uart_rx
   import uart_tx_rx_pkg::*;
#(
   parameter int unsigned c_CYCLES_PER_BIT = 217
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 serial,
   output logic [DATA_BITS-1:0] data,
   output logic                 data_valid
);

   localparam int unsigned CW = $clog2(c_CYCLES_PER_BIT);
   localparam logic [CW-1:0] CNT_LAST = CW'(c_CYCLES_PER_BIT - 1);
   // Last cycle of the first half of the start bit: the mid-start sample point.
   localparam logic [CW-1:0] CNT_HALF = CW'(c_CYCLES_PER_BIT / 2 - 1);
   localparam logic [2:0]    IDX_LAST = 3'(DATA_BITS - 1);

   logic [1:0]           sync_q;
   rx_state_e            state_q, state_d;
   logic [CW-1:0]        cnt_q, cnt_d;
   logic [2:0]           idx_q, idx_d;
   logic [DATA_BITS-1:0] shift_q, shift_d;
   logic [DATA_BITS-1:0] data_q, data_d;
   logic                 valid_q, valid_d;
   logic                 rx_bit;

   assign rx_bit     = sync_q[1];
   assign data       = data_q;
   assign data_valid = valid_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync_q  <= {2{LINE_IDLE}};
         state_q <= RxIdle;
         cnt_q   <= '0;
         idx_q   <= '0;
         shift_q <= '0;
         data_q  <= '0;
         valid_q <= 1'b0;
      end else begin
         sync_q  <= {sync_q[0], serial};
         state_q <= state_d;
         cnt_q   <= cnt_d;
         idx_q   <= idx_d;
         shift_q <= shift_d;
         data_q  <= data_d;
         valid_q <= valid_d;
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      idx_d   = idx_q;
      shift_d = shift_q;
      data_d  = data_q;
      valid_d = 1'b0;
      case (state_q)
         RxIdle: begin
            cnt_d = '0;
            idx_d = '0;
            if (!rx_bit) state_d = RxStart;
         end
         RxStart: begin
            if (cnt_q == CNT_HALF) begin
               cnt_d   = '0;
               // A line back high at mid-start is a glitch, not a frame.
               state_d = rx_bit ? RxIdle : RxData;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         RxData: begin
            if (cnt_q == CNT_LAST) begin
               cnt_d          = '0;
               shift_d[idx_q] = rx_bit;
               if (idx_q == IDX_LAST) begin
                  idx_d   = '0;
                  state_d = RxStop;
               end else begin
                  idx_d = idx_q + 3'd1;
               end
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         RxStop: begin
            if (cnt_q == CNT_LAST) begin
               cnt_d = '0;
               // A low stop bit is a framing error: drop the byte silently.
               if (rx_bit) begin
                  data_d  = shift_q;
                  valid_d = 1'b1;
               end
               state_d = RxCleanup;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         RxCleanup: begin
            // Hold here until the line is released so a stuck-low line is one frame.
            if (rx_bit) state_d = RxIdle;
         end
         default: state_d = RxIdle;
      endcase
   end

endmodule

// File: rtl/uart_tx_rx.sv
// UART transmitter and receiver, 8N1, independent TX and RX paths.
// Ports:
//   i_CLK / i_RESET_n   - clock, asynchronous active-low reset
//   i_TX_DV             - transmit request, sampled only while TX is idle
//   i_PARALLEL_DATA     - byte to transmit, latched with the request
//   o_SERIAL_DATA       - TX line, idle high
//   o_TX_ACTIVE         - high for the whole start..stop span of a frame
//   o_TX_DONE           - one-cycle pulse after the stop bit
//   i_SERIAL_DATA       - RX line (asynchronous)
//   o_DATA_RX           - last received byte
//   o_RX_DATA_VALID     - one-cycle pulse when o_DATA_RX updates
module uart_tx_rx
   import uart_tx_rx_pkg::*;
#(
   parameter int unsigned c_CYCLES_PER_BIT = 217
) (
   input  logic                 i_CLK,
   input  logic                 i_RESET_n,
   input  logic                 i_TX_DV,
   input  logic [DATA_BITS-1:0] i_PARALLEL_DATA,
   output logic                 o_SERIAL_DATA,
   output logic                 o_TX_ACTIVE,
   output logic                 o_TX_DONE,
   input  logic                 i_SERIAL_DATA,
   output logic [DATA_BITS-1:0] o_DATA_RX,
   output logic                 o_RX_DATA_VALID
);

   localparam int unsigned CW = $clog2(c_CYCLES_PER_BIT);
   localparam logic [CW-1:0] CNT_LAST = CW'(c_CYCLES_PER_BIT - 1);
   localparam logic [2:0]    IDX_LAST = 3'(DATA_BITS - 1);

   tx_state_e            tx_state_q, tx_state_d;
   logic [CW-1:0]        tx_cnt_q, tx_cnt_d;
   logic [2:0]           tx_idx_q, tx_idx_d;
   logic [DATA_BITS-1:0] tx_data_q, tx_data_d;

   always_ff @(posedge i_CLK or negedge i_RESET_n) begin
      if (!i_RESET_n) begin
         tx_state_q <= TxIdle;
         tx_cnt_q   <= '0;
         tx_idx_q   <= '0;
         tx_data_q  <= '0;
      end else begin
         tx_state_q <= tx_state_d;
         tx_cnt_q   <= tx_cnt_d;
         tx_idx_q   <= tx_idx_d;
         tx_data_q  <= tx_data_d;
      end
   end

   always_comb begin
      tx_state_d = tx_state_q;
      tx_cnt_d   = tx_cnt_q;
      tx_idx_d   = tx_idx_q;
      tx_data_d  = tx_data_q;
      case (tx_state_q)
         TxIdle: begin
            tx_cnt_d = '0;
            tx_idx_d = '0;
            if (i_TX_DV) begin
               tx_data_d  = i_PARALLEL_DATA;
               tx_state_d = TxStart;
            end
         end
         TxStart: begin
            if (tx_cnt_q == CNT_LAST) begin
               tx_cnt_d   = '0;
               tx_state_d = TxData;
            end else begin
               tx_cnt_d = tx_cnt_q + 1'b1;
            end
         end
         TxData: begin
            if (tx_cnt_q == CNT_LAST) begin
               tx_cnt_d = '0;
               if (tx_idx_q == IDX_LAST) begin
                  tx_idx_d   = '0;
                  tx_state_d = TxStop;
               end else begin
                  tx_idx_d = tx_idx_q + 3'd1;
               end
            end else begin
               tx_cnt_d = tx_cnt_q + 1'b1;
            end
         end
         TxStop: begin
            if (tx_cnt_q == CNT_LAST) begin
               tx_cnt_d   = '0;
               tx_state_d = TxDone;
            end else begin
               tx_cnt_d = tx_cnt_q + 1'b1;
            end
         end
         TxDone:  tx_state_d = TxIdle;
         default: tx_state_d = TxIdle;
      endcase
   end

   // Outputs decode the state register directly so reset forces them at once.
   always_comb begin
      o_SERIAL_DATA = LINE_IDLE;
      o_TX_ACTIVE   = 1'b0;
      o_TX_DONE     = 1'b0;
      case (tx_state_q)
         TxStart: begin
            o_SERIAL_DATA = ~LINE_IDLE;
            o_TX_ACTIVE   = 1'b1;
         end
         TxData: begin
            o_SERIAL_DATA = tx_data_q[tx_idx_q];
            o_TX_ACTIVE   = 1'b1;
         end
         TxStop:  o_TX_ACTIVE = 1'b1;
         TxDone:  o_TX_DONE = 1'b1;
         default: ;
      endcase
   end

   uart_rx #(
      .c_CYCLES_PER_BIT(c_CYCLES_PER_BIT)
   ) u_uart_rx (
      .clk       (i_CLK),
      .rst_n     (i_RESET_n),
      .serial    (i_SERIAL_DATA),
      .data      (o_DATA_RX),
      .data_valid(o_RX_DATA_VALID)
   );

endmodule

// File: tb/tb_uart_tx_rx.sv
module tb_uart_tx_rx;

   localparam int CPB  = 217;
   localparam int CPB4 = 4;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       tx_dv;
   logic [7:0] tx_data;
   logic       tx_serial, tx_active, tx_done;
   logic       rx_in, rx_valid;
   logic [7:0] rx_data;
   logic       loop_sel, drv_line;

   logic       dv4;
   logic [7:0] data4;
   logic       serial4, active4, done4, valid4;
   logic [7:0] rx4;

   int checks = 0;
   int errors = 0;

   logic [7:0] rx_q[$];
   logic [7:0] rx4_q[$];
   int         done_cnt = 0;
   int         act_cnt  = 0;
   logic       wave [0:10*CPB+1];

   always #5 clk = ~clk;

   assign rx_in = loop_sel ? tx_serial : drv_line;

   uart_tx_rx #(.c_CYCLES_PER_BIT(CPB)) u_dut (
      .i_CLK          (clk),
      .i_RESET_n      (rst_n),
      .i_TX_DV        (tx_dv),
      .i_PARALLEL_DATA(tx_data),
      .o_SERIAL_DATA  (tx_serial),
      .o_TX_ACTIVE    (tx_active),
      .o_TX_DONE      (tx_done),
      .i_SERIAL_DATA  (rx_in),
      .o_DATA_RX      (rx_data),
      .o_RX_DATA_VALID(rx_valid)
   );

   // Minimum legal bit period, wired in loopback.
   uart_tx_rx #(.c_CYCLES_PER_BIT(CPB4)) u_dut4 (
      .i_CLK          (clk),
      .i_RESET_n      (rst_n),
      .i_TX_DV        (dv4),
      .i_PARALLEL_DATA(data4),
      .o_SERIAL_DATA  (serial4),
      .o_TX_ACTIVE    (active4),
      .o_TX_DONE      (done4),
      .i_SERIAL_DATA  (serial4),
      .o_DATA_RX      (rx4),
      .o_RX_DATA_VALID(valid4)
   );

   always @(negedge clk) begin
      if (rx_valid) rx_q.push_back(rx_data);
      if (valid4) rx4_q.push_back(rx4);
      if (tx_done) done_cnt++;
      if (tx_active) act_cnt++;
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Serial level of bit j of an 8N1 frame carrying b (0 = start, 9 = stop).
   function automatic logic frame_bit(input logic [7:0] b, input int j);
      if (j == 0) return 1'b0;
      if (j == 9) return 1'b1;
      return b[j-1];
   endfunction

   function automatic logic [8:0] rx_at(input int i);
      if (i < rx_q.size()) return {1'b0, rx_q[i]};
      return 9'h1FF;
   endfunction

   function automatic logic [8:0] rx4_at(input int i);
      if (i < rx4_q.size()) return {1'b0, rx4_q[i]};
      return 9'h1FF;
   endfunction

   task automatic drive_frame(input logic [7:0] b, input logic stop);
      for (int j = 0; j < 10; j++) begin
         drv_line = (j == 9) ? stop : frame_bit(b, j);
         repeat (CPB) @(negedge clk);
      end
   endtask

   task automatic start_tx(input logic [7:0] b);
      tx_data = b;
      tx_dv   = 1'b1;
      @(negedge clk);
      tx_dv = 1'b0;
   endtask

   task automatic wait_done(input int bound, output bit ok);
      ok = 1'b0;
      for (int i = 0; i < bound; i++) begin
         @(negedge clk);
         if (tx_done) begin
            ok = 1'b1;
            break;
         end
      end
   endtask

   initial begin
      int r0, d0, a0, mm, rnd;
      bit ok;
      logic [7:0] b;
      logic [7:0] exp_q[$];

      rst_n    = 1'b0;
      tx_dv    = 1'b0;
      tx_data  = 8'h00;
      dv4      = 1'b0;
      data4    = 8'h00;
      loop_sel = 1'b1;
      drv_line = 1'b1;
      repeat (3) @(negedge clk);
      check("rst_serial", tx_serial, 1);
      check("rst_active", tx_active, 0);
      check("rst_done", tx_done, 0);
      check("rst_rx_data", rx_data, 8'h00);
      check("rst_rx_valid", rx_valid, 0);
      rst_n = 1'b1;
      repeat (3) @(negedge clk);

      // Loopback of 0x27.
      r0 = rx_q.size(); d0 = done_cnt; a0 = act_cnt;
      start_tx(8'h27);
      repeat (11 * CPB) @(negedge clk);
      check("lb27_active_cycles", act_cnt - a0, 10 * CPB);
      check("lb27_done_pulses", done_cnt - d0, 1);
      check("lb27_rx_count", rx_q.size() - r0, 1);
      check("lb27_rx_byte", rx_at(r0), 9'h027);

      // TX waveform of 0xA5, sample k is k cycles after the request edge.
      r0 = rx_q.size();
      tx_data = 8'hA5;
      tx_dv   = 1'b1;
      wave[0] = tx_serial;
      check("a5_active_before", tx_active, 0);
      for (int k = 1; k <= 10 * CPB + 1; k++) begin
         @(negedge clk);
         wave[k] = tx_serial;
         if (k == 1) begin
            check("a5_active_first", tx_active, 1);
            tx_dv = 1'b0;
         end
      end
      check("a5_done_after_stop", tx_done, 1);
      check("a5_idle_before", wave[0], 1);
      for (int j = 0; j < 10; j++) begin
         mm = 0;
         for (int k = j * CPB + 1; k <= (j + 1) * CPB; k++)
            if (wave[k] !== frame_bit(8'hA5, j)) mm++;
         check($sformatf("a5_bit%0d_mismatch", j), mm, 0);
      end
      check("a5_idle_after", wave[10 * CPB + 1], 1);
      repeat (CPB) @(negedge clk);
      check("a5_rx_byte", rx_at(r0), 9'h0A5);

      // Short glitch on RX, then a real frame.
      loop_sel = 1'b0;
      drv_line = 1'b1;
      repeat (5) @(negedge clk);
      r0 = rx_q.size();
      drv_line = 1'b0;
      repeat (50) @(negedge clk);
      drv_line = 1'b1;
      repeat (2 * CPB) @(negedge clk);
      check("glitch_no_valid", rx_q.size() - r0, 0);
      drive_frame(8'h3C, 1'b1);
      drv_line = 1'b1;
      repeat (CPB) @(negedge clk);
      check("after_glitch_count", rx_q.size() - r0, 1);
      check("after_glitch_byte", rx_at(r0), 9'h03C);

      // Framing error, line held low past the stop bit, then a good 0x00.
      r0 = rx_q.size();
      drive_frame(8'hFF, 1'b0);
      repeat (CPB) @(negedge clk);
      drv_line = 1'b1;
      repeat (2 * CPB) @(negedge clk);
      check("frame_err_no_valid", rx_q.size() - r0, 0);
      check("frame_err_data_held", rx_data, 8'h3C);
      drive_frame(8'h00, 1'b1);
      drv_line = 1'b1;
      repeat (CPB) @(negedge clk);
      check("after_err_count", rx_q.size() - r0, 1);
      check("after_err_byte", rx_at(r0), 9'h000);

      // Back-to-back frames with the request held high.
      loop_sel = 1'b1;
      repeat (5) @(negedge clk);
      r0 = rx_q.size(); d0 = done_cnt;
      tx_data = 8'h55;
      tx_dv   = 1'b1;
      @(negedge clk);
      tx_data = 8'hAA;
      wait_done(11 * CPB, ok);
      check("b2b_first_done", ok, 1);
      ok = 1'b0;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         if (tx_active) begin
            ok = 1'b1;
            break;
         end
      end
      check("b2b_second_start", ok, 1);
      tx_dv = 1'b0;
      wait_done(11 * CPB, ok);
      check("b2b_second_done", ok, 1);
      repeat (CPB) @(negedge clk);
      check("b2b_done_pulses", done_cnt - d0, 2);
      check("b2b_rx_first", rx_at(r0), 9'h055);
      check("b2b_rx_second", rx_at(r0 + 1), 9'h0AA);

      // Random loopback; mid-frame data changes and requests must be ignored.
      r0 = rx_q.size(); d0 = done_cnt;
      for (int f = 0; f < 10; f++) begin
         b = 8'($urandom);
         exp_q.push_back(b);
         start_tx(b);
         rnd = $urandom_range(9 * CPB, 2);
         repeat (rnd) @(negedge clk);
         tx_data = 8'($urandom);
         tx_dv   = 1'b1;
         @(negedge clk);
         tx_dv = 1'b0;
         repeat (10 * CPB + 4 - rnd) @(negedge clk);
      end
      check("rand_done_pulses", done_cnt - d0, 10);
      for (int f = 0; f < 10; f++)
         check($sformatf("rand_rx%0d", f), rx_at(r0 + f), {1'b0, exp_q[f]});

      // Minimum bit period loopback.
      exp_q.delete();
      for (int f = 0; f < 8; f++) begin
         b = 8'($urandom);
         exp_q.push_back(b);
         data4 = b;
         dv4   = 1'b1;
         @(negedge clk);
         dv4 = 1'b0;
         repeat (10 * CPB4 + 6) @(negedge clk);
      end
      for (int f = 0; f < 8; f++)
         check($sformatf("cpb4_rx%0d", f), rx4_at(f), {1'b0, exp_q[f]});

      // Reset in the middle of a TX data bit.
      r0 = rx_q.size(); d0 = done_cnt;
      start_tx(8'hC3);
      repeat (5 * CPB) @(negedge clk);
      #2 rst_n = 1'b0;
      #1;
      check("rst_mid_serial", tx_serial, 1);
      check("rst_mid_active", tx_active, 0);
      @(negedge clk);
      check("rst_mid_rx_data", rx_data, 8'h00);
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      repeat (12 * CPB) @(negedge clk);
      check("rst_mid_no_valid", rx_q.size() - r0, 0);
      check("rst_mid_no_done", done_cnt - d0, 0);
      check("rst_mid_tx_idle", tx_active, 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
